// File: rtl/adder_unit.sv
// ----------------------------------------------------------------------------
// adder_unit
//
// Two-operand BUS_SIZE-bit adder for PC increment and branch-target math.
// It has two output paths:
//    - A zero-latency combinational sum with unsigned carry and signed
//      overflow flags.
//    - A one-stage registered copy of the same results, qualified by
//      out_valid, for timing-critical consumers.
//
// Build option: ADDER_SAT_EN
//    - Defined: the registered sum saturates to all-ones on unsigned carry.
//      carry_q and overflow_q still report the raw flags, and the
//      combinational sum always wraps.
//    - Undefined (default): the registered sum is the wrapped sum.
//
// Ports:
//    clk         in   1          rising-edge clock (registered path only)
//    rst_n       in   1          asynchronous active-low reset
//    a           in   BUS_SIZE   operand A (unsigned or two's complement)
//    b           in   BUS_SIZE   operand B
//    in_valid    in   1          qualifies a/b for the registered path
//    sum         out  BUS_SIZE   combinational a+b, modulo 2^BUS_SIZE
//    carry       out  1          combinational unsigned carry-out
//    overflow    out  1          combinational signed overflow
//    sum_q       out  BUS_SIZE   registered sum (saturating with ADDER_SAT_EN)
//    carry_q     out  1          registered carry
//    overflow_q  out  1          registered overflow
//    out_valid   out  1          registered in_valid
// ----------------------------------------------------------------------------
module adder_unit #(
   parameter int BUS_SIZE = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BUS_SIZE-1:0] a,
   input  logic [BUS_SIZE-1:0] b,
   input  logic                in_valid,
   output logic [BUS_SIZE-1:0] sum,
   output logic                carry,
   output logic                overflow,
   output logic [BUS_SIZE-1:0] sum_q,
   output logic                carry_q,
   output logic                overflow_q,
   output logic                out_valid
);

   localparam int MSB = BUS_SIZE - 1;

   logic [BUS_SIZE:0]   full_sum;
   logic [BUS_SIZE-1:0] sum_d;
   logic                carry_d;
   logic                overflow_d;
   logic                out_valid_d;

   // One extra bit of width so the carry-out falls out of the add directly.
   assign full_sum = {1'b0, a} + {1'b0, b};
   assign sum      = full_sum[MSB:0];
   assign carry    = full_sum[BUS_SIZE];
   // Signed overflow: operands agree in sign, but the result does not.
   assign overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      out_valid_d = in_valid;
      if (in_valid) begin
`ifdef ADDER_SAT_EN
         sum_d = carry ? {BUS_SIZE{1'b1}} : sum;
`else
         sum_d = sum;
`endif
         carry_d    = carry;
         overflow_d = overflow;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q      <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         out_valid  <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_adder_unit.sv
// ----------------------------------------------------------------------------
// tb_adder_unit
//
// Directed and random stimulus for adder_unit (BUS_SIZE = 32). The expected
// results come from a reference model that uses 64-bit integer arithmetic.
// ----------------------------------------------------------------------------
module tb_adder_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_valid;
   logic [31:0] sum;
   logic        carry;
   logic        overflow;
   logic [31:0] sum_q;
   logic        carry_q;
   logic        overflow_q;
   logic        out_valid;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state for the registered path.
   logic [31:0] m_sum_q;
   logic        m_carry_q;
   logic        m_ovf_q;
   logic        m_valid_q;

   adder_unit #(.BUS_SIZE(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid),
      .sum        (sum),
      .carry      (carry),
      .overflow   (overflow),
      .sum_q      (sum_q),
      .carry_q    (carry_q),
      .overflow_q (overflow_q),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compute the reference results from integer arithmetic.
   task automatic ref_add(input logic [31:0] ta, input logic [31:0] tb_,
                          output logic [31:0] rs, output logic rc, output logic ro,
                          output logic [31:0] rsat);
      longint unsigned u;
      longint          s;
      u  = longint'({32'h0, ta}) + longint'({32'h0, tb_});
      s  = longint'($signed(ta)) + longint'($signed(tb_));
      rs = u[31:0];
      rc = (u > 64'h0000_0000_FFFF_FFFF);
      ro = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef ADDER_SAT_EN
      rsat = rc ? 32'hFFFF_FFFF : rs;
`else
      rsat = rs;
`endif
   endtask

   // Drive the operands on the falling edge and check the combinational outputs
   // 1 ns later. Then check the registered outputs 1 ns after the next rising edge.
   task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tv);
      logic [31:0] rs, rsat;
      logic        rc, ro;
      @(negedge clk);
      a        = ta;
      b        = tb_;
      in_valid = tv;
      ref_add(ta, tb_, rs, rc, ro, rsat);
      #1;
      chk({tag, ".sum"},      {32'h0, sum}, {32'h0, rs});
      chk({tag, ".carry"},    {63'h0, carry}, {63'h0, rc});
      chk({tag, ".overflow"}, {63'h0, overflow}, {63'h0, ro});
      if (tv) begin
         m_sum_q   = rsat;
         m_carry_q = rc;
         m_ovf_q   = ro;
      end
      m_valid_q = tv;
      @(posedge clk);
      #1;
      chk({tag, ".sum_q"},      {32'h0, sum_q}, {32'h0, m_sum_q});
      chk({tag, ".carry_q"},    {63'h0, carry_q}, {63'h0, m_carry_q});
      chk({tag, ".overflow_q"}, {63'h0, overflow_q}, {63'h0, m_ovf_q});
      chk({tag, ".out_valid"},  {63'h0, out_valid}, {63'h0, m_valid_q});
   endtask

   task automatic chk_reset_regs(input string tag);
      chk({tag, ".sum_q"},      {32'h0, sum_q}, 64'h0);
      chk({tag, ".carry_q"},    {63'h0, carry_q}, 64'h0);
      chk({tag, ".overflow_q"}, {63'h0, overflow_q}, 64'h0);
      chk({tag, ".out_valid"},  {63'h0, out_valid}, 64'h0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst_n    = 1'b1;
      a        = '0;
      b        = '0;
      in_valid = 1'b0;
      m_sum_q   = '0;
      m_carry_q = 1'b0;
      m_ovf_q   = 1'b0;
      m_valid_q = 1'b0;

      // Asynchronous reset is applied between clock edges.
      #2 rst_n = 1'b0;
      #1;
      chk_reset_regs("por");
      chk("zero.sum",      {32'h0, sum}, 64'h0);
      chk("zero.carry",    {63'h0, carry}, 64'h0);
      chk("zero.overflow", {63'h0, overflow}, 64'h0);

      @(negedge clk);
      rst_n = 1'b1;

      // Random operand pairs, one per 10 ns, with a random valid.
      for (int i = 0; i < 10; i++) begin
         ra = $urandom();
         rb = $urandom();
         step($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
      end

      // Boundaries.
      step("zero",     32'h0000_0000, 32'h0000_0000, 1'b1);
      step("ones_p1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
`ifdef ADDER_SAT_EN
      chk("ones_p1.sat", {32'h0, sum_q}, 64'h0000_0000_FFFF_FFFF);
`else
      chk("ones_p1.wrap", {32'h0, sum_q}, 64'h0);
`endif
      step("maxpos_p1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      chk("maxpos_p1.const", {32'h0, sum}, 64'h0000_0000_8000_0000);
      step("minneg_x2", 32'h8000_0000, 32'h8000_0000, 1'b1);
      chk("minneg_x2.flags", {62'h0, carry, overflow}, 64'h3);

      // Valid followed by invalid: the registered result must hold.
      step("hold_v", 32'd3, 32'd4, 1'b1);
      step("hold_i", 32'd9, 32'd0, 1'b0);
      chk("hold.sum_q_7", {32'h0, sum_q}, 64'd7);

      // Reset while out_valid=1 must act before any clock edge.
      step("pre_rst", 32'd100, 32'd23, 1'b1);
      chk("pre_rst.valid1", {63'h0, out_valid}, 64'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_regs("mid_rst");
      in_valid = 1'b1;
      a = 32'd5;
      b = 32'd6;
      @(posedge clk);
      #1;
      chk_reset_regs("held_rst");
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      m_sum_q   = '0;
      m_carry_q = 1'b0;
      m_ovf_q   = 1'b0;
      m_valid_q = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_regs("post_rst");
      step("post_rst_v", 32'h1234_5678, 32'h0000_0008, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
